seg_scan_arbiter: RTL and testbench
===================================

// Module: seg_scan_arbiter
// PURPOSE
//   Shares the board's single 4-digit seven-segment display between three
//   requesters, for example the per-subtask display logic.
//   Grants the display to one requester per frame, using fixed priority.
//   Latches the owner's frame data, then scans the four digits with
//   anti-ghost blanking.
//   Drives the active-low an/seg/dp pins directly.
//   Arbitration happens only at frame boundaries, so a frame is never torn.
// PARAMETERS
//   SCAN_DIV   100_000  clk cycles per digit slot (1 kHz/digit at 100 MHz); >=2
//   GHOST_CYC  2_000    cycles at the start of each slot with all anodes off; < SCAN_DIV
// PORTS
//   clk          in   1   system clock, 100 MHz
//   rst_n        in   1   asynchronous reset, active low
//   req          in   3   display request; req[0] highest priority, req[2] lowest
//   frame0       in   32  requester 0 frame: byte k = {dp_n, seg_n[6:0]} for digit k (k=0 rightmost)
//   frame1       in   32  requester 1 frame, same layout as frame0
//   frame2       in   32  requester 2 frame, same layout as frame0
//   mask0        in   4   requester 0 digit enable; 0 = digit dark
//   mask1        in   4   requester 1 digit enable, same meaning as mask0
//   mask2        in   4   requester 2 digit enable, same meaning as mask0
//   grant        out  3   one-hot current owner; 000 = display idle
//   frame_start  out  1   1-cycle pulse when a new frame's ownership takes effect
//   an           out  4   anodes, active low
//   seg          out  7   segments {g..a}, active low
//   dp           out  1   decimal point, active low
// BEHAVIOUR
//   Reset (asynchronous, takes effect immediately while rst_n=0):
//   - cnt=0, digit=0, grant=000, frame_start=0.
//   - Latched frame = 32'hFFFF_FFFF, latched mask = 0000.
//   - an=1111, seg=7'h7F, dp=1.
//   Slot timing:
//   - cnt counts 0..SCAN_DIV-1, then wraps; tick = (cnt==SCAN_DIV-1).
//   - On tick, digit <= digit+1 mod 4 (digit order 0,1,2,3,0...).
//   Frame boundary = tick while digit==3. In that same edge:
//   - grant <= one-hot of the highest-priority asserted req bit, or 000 if none.
//   - The granted requester's frame and mask are sampled and latched.
//     With no requester, latch all-ones frame and mask 0000.
//   - frame_start <= 1 for exactly one cycle. It pulses on every boundary,
//     including idle and same-owner boundaries.
//   Between boundaries:
//   - req, frame and mask changes are ignored.
//   - grant holds even if the owner drops req; the new owner appears at the next boundary.
//   - Fixed priority only; a lower requester may starve. This is intended.
//   Outputs (all registered; they reflect cnt/digit of the previous cycle):
//   - if cnt < GHOST_CYC, or latched mask[digit]==0: an=1111.
//   - else an = ~(4'b0001 << digit).
//   - seg/dp = latched byte[digit] every cycle, even while blanked.
//   First ownership after reset:
//   - first boundary occurs 4*SCAN_DIV-1 cycles after rst_n rises.
//   - grant and frame_start are visible on the next cycle.
//   - display is dark until then.
//   Widths:
//   - cnt is $clog2(SCAN_DIV) bits.
//   - digit is 2 bits and wraps naturally.
//   - no arithmetic is done on frame data.
//   Reset mid-frame: everything returns to reset values immediately.
//   Scanning restarts at digit 0 after release.
// TESTING   (SCAN_DIV=8, GHOST_CYC=2)
//   - Reset and idle: rst_n=0 for 3 cycles, then req=000 for 64 cycles.
//     -> an=1111, seg=7F, dp=1 and grant=000 throughout; frame_start pulses every 32 cycles.
//   - Single owner: req=010, frame1=32'hF9_A4_B0_C0, mask1=1111.
//     -> grant=010 one cycle after the first boundary.
//     -> in digit-0 slot, cnt>=2: an=1110, seg=7'h40, dp=1.
//     -> in digit-3 slot: an=0111, seg=7'h79.
//   - Contention: req=111 -> grant=001 at the boundary.
//     -> req changed to 110 mid-frame: grant stays 001 until the next boundary, then becomes 010.
//   - Frame and mask latching: change frame0 during digit 1 -> display unchanged until the next frame.
//     -> mask0=0101: an[1] and an[3] never go low.
//   - Ghost blanking: in every slot, an=1111 for the first 2 cycles, then one anode goes low for 6 cycles.
//   - Async reset mid-frame: drop rst_n during digit 2, cnt=5.
//     -> same cycle: an=1111, grant=000.
//     -> after release: digit restarts at 0; first frame_start at cycle 32.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// Fixed-priority owner of the 4-digit seven-segment display; re-arbitrates only at frame boundaries.
// Outputs are registered, one cycle behind the scan state; requesters see no backpressure, only grant.
module seg_scan_arbiter #(
  parameter int SCAN_DIV  = 100_000,
  parameter int GHOST_CYC = 2_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] frame0,
  input  logic [31:0] frame1,
  input  logic [31:0] frame2,
  input  logic [3:0]  mask0,
  input  logic [3:0]  mask1,
  input  logic [3:0]  mask2,
  output logic [2:0]  grant,
  output logic        frame_start,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GHOST   = CW'(GHOST_CYC);

  typedef struct packed {
    logic       dp_n;
    logic [6:0] seg_n;
  } digit_t;

  typedef digit_t [3:0] frame_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [2:0]    grant_q, grant_d;
  logic          frame_start_q, frame_start_d;
  frame_t        frame_q, frame_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          boundary;
  logic [2:0]    pick_grant;
  logic [31:0]   pick_frame;
  logic [3:0]    pick_mask;
  digit_t        cur_digit;
  logic          blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      digit_q       <= '0;
      grant_q       <= '0;
      frame_start_q <= 1'b0;
      frame_q       <= '1;
      mask_q        <= '0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      grant_q       <= grant_d;
      frame_start_q <= frame_start_d;
      frame_q       <= frame_d;
      mask_q        <= mask_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (digit_q == 2'd3);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    digit_d  = tick ? digit_q + 2'd1 : digit_q;
  end

  // Idle owner latches a dark frame so the blanked display carries no stale data.
  always_comb begin
    pick_grant = 3'b000;
    pick_frame = 32'hFFFF_FFFF;
    pick_mask  = 4'b0000;
    if (req[0]) begin
      pick_grant = 3'b001;
      pick_frame = frame0;
      pick_mask  = mask0;
    end else if (req[1]) begin
      pick_grant = 3'b010;
      pick_frame = frame1;
      pick_mask  = mask1;
    end else if (req[2]) begin
      pick_grant = 3'b100;
      pick_frame = frame2;
      pick_mask  = mask2;
    end
  end

  always_comb begin
    grant_d       = grant_q;
    frame_d       = frame_q;
    mask_d        = mask_q;
    frame_start_d = boundary;
    if (boundary) begin
      grant_d = pick_grant;
      frame_d = pick_frame;
      mask_d  = pick_mask;
    end
  end

  // Segment data follows the digit even while blanked; only the anodes gate visibility.
  always_comb begin
    cur_digit = frame_q[digit_q];
    blank     = (cnt_q < GHOST) || !mask_q[digit_q];
    an_d      = blank ? 4'hF : ~(4'b0001 << digit_q);
    seg_d     = cur_digit.seg_n;
    dp_d      = cur_digit.dp_n;
  end

  assign grant       = grant_q;
  assign frame_start = frame_start_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Randomized bench for seg_scan_arbiter against a cycle-count reference model.
module tb_seg_scan_arbiter;

  localparam int SD = 8;
  localparam int GC = 2;
  localparam int FRAME_CYC = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [31:0] frame0 = '0, frame1 = '0, frame2 = '0;
  logic [3:0]  mask0 = '0, mask1 = '0, mask2 = '0;
  logic [2:0]  grant;
  logic        frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;

  // Reference state: n = rising edges since reset release, plus the frame owned at the last boundary.
  int          n;
  logic [31:0] lat_f;
  logic [3:0]  lat_m;
  logic [2:0]  e_grant;
  logic        e_fs;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  seg_scan_arbiter #(.SCAN_DIV(SD), .GHOST_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .mask0(mask0), .mask1(mask1), .mask2(mask2),
    .grant(grant), .frame_start(frame_start),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    check("grant", 32'(grant), 32'(e_grant));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic model_reset();
    n       = 0;
    lat_f   = 32'hFFFF_FFFF;
    lat_m   = 4'b0000;
    e_grant = 3'b000;
    e_fs    = 1'b0;
    e_an    = 4'hF;
    e_seg   = 7'h7F;
    e_dp    = 1'b1;
  endtask

  // One clock: advance the model across the rising edge, then compare on the falling edge.
  task automatic step();
    int         c;
    int         d;
    logic [3:0] onehot;
    @(posedge clk);
    n++;
    c      = (n - 1) % SD;
    d      = ((n - 1) / SD) % 4;
    onehot = 4'b0001 << d;
    e_an   = (c < GC || !lat_m[d]) ? 4'hF : ~onehot;
    e_seg  = lat_f[8*d +: 7];
    e_dp   = lat_f[8*d + 7];
    e_fs   = (n % FRAME_CYC == 0);
    if (e_fs) begin
      if (req[0])      begin e_grant = 3'b001; lat_f = frame0; lat_m = mask0; end
      else if (req[1]) begin e_grant = 3'b010; lat_f = frame1; lat_m = mask1; end
      else if (req[2]) begin e_grant = 3'b100; lat_f = frame2; lat_m = mask2; end
      else             begin e_grant = 3'b000; lat_f = 32'hFFFF_FFFF; lat_m = 4'b0000; end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic run_until(input int phase);
    int budget;
    budget = FRAME_CYC + 1;
    while ((n % FRAME_CYC) != phase && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("phase_timeout", 32'(n % FRAME_CYC), 32'(phase));
  endtask

  task automatic randomize_inputs();
    frame0 = $urandom; frame1 = $urandom; frame2 = $urandom;
    mask0  = 4'($urandom); mask1 = 4'($urandom); mask2 = 4'($urandom);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;

    // Idle: dark display, frame_start on every boundary.
    run(64);

    // Single owner with a known pattern.
    req = 3'b010; frame1 = 32'hF9_A4_B0_C0; mask1 = 4'b1111;
    randomize_inputs();
    frame1 = 32'hF9_A4_B0_C0; mask1 = 4'b1111;
    run(70);

    // Contention, then priority change mid-frame.
    req = 3'b111;
    run_until(1);
    run_until(16);
    req = 3'b110;
    run(48);

    // Latching: frame0 moves during digit 1, mask hides digits 1 and 3.
    req = 3'b001; mask0 = 4'b0101; frame0 = $urandom;
    run_until(1);
    run_until(9);
    frame0 = $urandom; mask0 = 4'b1111;
    run(40);

    // Random traffic with mid-frame input churn.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) randomize_inputs();
      step();
    end

    // Asynchronous reset during digit 2, cnt 5.
    req = 3'b001; randomize_inputs(); mask0 = 4'b1111;
    run_until(1);
    run_until(21);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run_until(0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) randomize_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
